// File: rtl/rf_write_arbiter_if.sv
// Handshake bundle between the two register-file write requesters and rf_write_arbiter,
// plus the arbiter's registered write port and contention counter.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 2
);
    logic              req0_valid;
    logic [ADR_W-1:0]  req0_adr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADR_W-1:0]  req1_adr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              write_en;
    logic [ADR_W-1:0]  write_adr;
    logic [DATA_W-1:0] write_data;
    logic              grant_id;
    logic [7:0]        conflict_cnt;

    // Requester side (ALU writeback and load unit, plus the register file observing the write port).
    modport master (
        output req0_valid, req0_adr, req0_data,
        input  req0_ready,
        output req1_valid, req1_adr, req1_data,
        input  req1_ready,
        input  write_en, write_adr, write_data, grant_id, conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_adr, req0_data,
        output req0_ready,
        input  req1_valid, req1_adr, req1_data,
        output req1_ready,
        output write_en, write_adr, write_data, grant_id, conflict_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with a registered single write port.
// Define RF_ARB_ROUND_ROBIN_EN for alternating priority; otherwise the load unit (req1) always wins.
module rf_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 2
) (
    input logic          clk,
    input logic          reset,
    rf_write_arbiter_if.slave bus
);

    logic              contended;
    logic              any_valid;
    logic              xfer;
    logic              winner;
    logic [ADR_W-1:0]  win_adr;
    logic [DATA_W-1:0] win_data;

    logic              write_en_q;
    logic [ADR_W-1:0]  write_adr_q;
    logic [DATA_W-1:0] write_data_q;
    logic              grant_id_q;
    logic [7:0]        conflict_cnt_q;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic              prio_ptr;
`endif

    assign contended = bus.req0_valid & bus.req1_valid;
    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Requests offered while reset is high are never accepted, so nothing leaks past reset.
    assign xfer      = any_valid & ~reset;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        winner = 1'b0;
        if (contended) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            winner = prio_ptr;
`else
            winner = 1'b1;
`endif
        end else begin
            winner = bus.req1_valid;
        end
    end

    always_comb begin
        win_adr  = bus.req0_adr;
        win_data = bus.req0_data;
        if (winner) begin
            win_adr  = bus.req1_adr;
            win_data = bus.req1_data;
        end
    end

    assign bus.req0_ready = xfer & ~winner;
    assign bus.req1_ready = xfer &  winner;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
        if (reset) begin
            write_en_q     <= 1'b0;
            write_adr_q    <= '0;
            write_data_q   <= '0;
            grant_id_q     <= 1'b0;
            conflict_cnt_q <= 8'd0;
        end else begin
            write_en_q <= xfer;
            if (xfer) begin
                write_adr_q  <= win_adr;
                write_data_q <= win_data;
                grant_id_q   <= winner;
            end
            if (contended && (conflict_cnt_q != 8'hFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 8'd1;
            end
        end
    end

`ifdef RF_ARB_ROUND_ROBIN_EN
    // After a contended grant the loser gets priority next time; uncontended grants leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_ptr <= 1'b0;
        end else if (contended) begin
            prio_ptr <= ~winner;
        end
    end
`endif

    assign bus.write_en     = write_en_q;
    assign bus.write_adr    = write_adr_q;
    assign bus.write_data   = write_data_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.conflict_cnt = conflict_cnt_q;

    a_ready_exclusive : assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));
    a_no_ready_in_reset : assert property (@(posedge clk) reset |-> !(bus.req0_ready || bus.req1_ready));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: a transaction-level model predicts every
// cycle's write port state and a separate monitor compares it against the DUT.
module tb_rf_write_arbiter;
    localparam int DATA_W = 16;
    localparam int ADR_W  = 2;

    typedef struct {
        logic              en;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
        logic              id;
        int                cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W)) bus ();

    rf_write_arbiter #(.DATA_W(DATA_W), .ADR_W(ADR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b1;
    exp_t sb[$];

    // Requester-side pending requests, held until accepted.
    logic              h_v[2];
    logic [ADR_W-1:0]  h_adr[2];
    logic [DATA_W-1:0] h_data[2];

    // Reference model state.
    int                m_win = -1;
    int                m_cnt = 0;
    logic [ADR_W-1:0]  m_adr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_id = 1'b0;
`ifdef RF_ARB_ROUND_ROBIN_EN
    int                m_ptr = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   win;
        win = -1;
        if (reset) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            m_ptr = 0;
`endif
            m_cnt  = 0;
            m_adr  = '0;
            m_data = '0;
            m_id   = 1'b0;
        end else begin
            if (h_v[0] && h_v[1]) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
                win   = m_ptr;
                m_ptr = 1 - win;
`else
                win = 1;
`endif
                if (m_cnt < 255) m_cnt++;
            end else if (h_v[0]) begin
                win = 0;
            end else if (h_v[1]) begin
                win = 1;
            end
            if (win >= 0) begin
                m_adr  = h_adr[win];
                m_data = h_data[win];
                m_id   = win[0];
            end
        end
        e.en   = (win >= 0);
        e.adr  = m_adr;
        e.data = m_data;
        e.id   = m_id;
        e.cnt  = m_cnt;
        check("req0_ready", 32'(bus.req0_ready), 32'(win == 0));
        check("req1_ready", 32'(bus.req1_ready), 32'(win == 1));
        sb.push_back(e);
        m_win = win;
    endtask

    // One clock: retire the request accepted last edge, refill with probability p0/p1 (percent),
    // drive, let the model predict at the falling edge, then step past the rising edge.
    task automatic cycle(input int p0, input int p1, input bit rst);
        int p[2];
        p[0] = p0;
        p[1] = p1;
        if (m_win >= 0) h_v[m_win] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!h_v[i] && ($urandom_range(99) < p[i])) begin
                h_v[i]    = 1'b1;
                h_adr[i]  = ADR_W'($urandom_range(3));
                h_data[i] = DATA_W'($urandom);
            end
        end
        reset          = rst;
        bus.req0_valid = h_v[0];
        bus.req0_adr   = h_adr[0];
        bus.req0_data  = h_data[0];
        bus.req1_valid = h_v[1];
        bus.req1_adr   = h_adr[1];
        bus.req1_data  = h_data[1];
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        h_v[0] = 1'b0;
        h_v[1] = 1'b0;
        m_win  = -1;
    endtask

    // Monitor: one expected write-port state per cycle, popped in order.
    initial begin : monitor
        exp_t e;
        wait (sb.size() > 0);
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected an entry (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("write_en",     32'(bus.write_en),     32'(e.en));
                    check("write_adr",    32'(bus.write_adr),    32'(e.adr));
                    check("write_data",   32'(bus.write_data),   32'(e.data));
                    check("grant_id",     32'(bus.grant_id),     32'(e.id));
                    check("conflict_cnt", 32'(bus.conflict_cnt), 32'(e.cnt));
                end
            end
        end
    end

    initial begin : stimulus
        h_adr[0] = '0; h_adr[1] = '0;
        h_data[0] = '0; h_data[1] = '0;
        clear_reqs();
        repeat (2) cycle(0, 0, 1'b1);

        // Single request from req0.
        h_v[0] = 1'b1; h_adr[0] = 2'd2; h_data[0] = 16'hFFFF;
        cycle(0, 0, 1'b0);
        repeat (2) cycle(0, 0, 1'b0);

        // Four cycles of contention straight after reset.
        clear_reqs();
        cycle(0, 0, 1'b1);
        repeat (4) cycle(100, 100, 1'b0);
        clear_reqs();
        repeat (2) cycle(0, 0, 1'b0);

        // Both requesters hit the same register together.
        h_v[0] = 1'b1; h_adr[0] = 2'd1; h_data[0] = 16'hAAAA;
        h_v[1] = 1'b1; h_adr[1] = 2'd1; h_data[1] = 16'h5555;
        cycle(0, 0, 1'b0);
        cycle(0, 0, 1'b0);
        repeat (2) cycle(0, 0, 1'b0);

        // Reset right after a transfer, with requests present in the reset cycle.
        h_v[0] = 1'b1; h_adr[0] = 2'd3; h_data[0] = 16'h1234;
        cycle(0, 0, 1'b0);
        cycle(100, 100, 1'b1);
        repeat (3) cycle(0, 0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(40, 40, ($urandom_range(99) == 0));
        end

        // Sustained contention to saturate the conflict counter.
        clear_reqs();
        cycle(0, 0, 1'b1);
        repeat (300) cycle(100, 100, 1'b0);
        clear_reqs();
        repeat (3) cycle(0, 0, 1'b0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the register data width.
REQ-002 The block SHALL have parameter ADR_W, default 2, the register address width (4 registers).
REQ-003 Ports SHALL be as follows, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
- req0_adr  input  ADR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 write value.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid / req1_adr / req1_data / req1_ready  same as requester 0, for the load unit.
- write_en  output  1  registered write strobe to the register file.
- write_adr  output  ADR_W  registered register-file write address.
- write_data  output  DATA_W  registered register-file write data.
- grant_id  output  1  registered ID of the requester that owns the current write_en cycle.
- conflict_cnt  output  8  count of cycles in which both requesters were valid.

Function
REQ-004 A request SHALL transfer when reqN_valid and reqN_ready are both high on a rising edge of clk.
REQ-005 reqN_ready SHALL be combinational and high for at most one requester per cycle, and never when reset is high.
REQ-006 If exactly one requester is valid, that requester SHALL be granted in the same cycle.
REQ-007 If both requesters are valid, the requester selected by the priority pointer SHALL be granted, and the other SHALL see ready low.
REQ-008 Priority pointer: a 1-bit register, reset value 0, that SHALL be set to the requester not granted after every contended grant; it SHALL NOT change on uncontended grants.
REQ-009 Latency: a transfer in cycle T SHALL produce write_en=1 with the matching adr/data/grant_id in cycle T+1.
REQ-010 write_en SHALL be 0 in any cycle following a cycle with no transfer.
REQ-011 write_adr, write_data and grant_id SHALL hold their last values while write_en=0.
REQ-012 A losing requester SHALL keep its valid/adr/data stable until accepted; the block SHALL NOT drop a held request.
REQ-013 If both requesters target the same address in the same cycle, the winner SHALL write first and the loser SHALL write in a later cycle, so the loser's value is the final register content.
REQ-014 Throughput: one transfer per cycle; continuous contention SHALL alternate grants 0,1,0,1...
REQ-015 conflict_cnt SHALL increment by 1 in each cycle with both valids high, and SHALL saturate at 255 without wrapping.
REQ-016 Valid inputs and ready outputs SHALL follow the same handshake as the register file's write port: one write per cycle, address and data captured together.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL set write_en=0, write_adr=0, write_data=0, grant_id=0, pointer=0 and conflict_cnt=0.
REQ-018 A transfer presented in a reset cycle SHALL be discarded, and write_en SHALL be 0 in the following cycle.
REQ-019 A write_en that was pending when reset asserted SHALL be deasserted on that edge; no register-file write SHALL occur after reset.

Configuration
REQ-020 Macro RF_ARB_ROUND_ROBIN_EN defined: contention SHALL be resolved by the pointer in REQ-007/REQ-008.
REQ-021 Macro RF_ARB_ROUND_ROBIN_EN undefined: requester 1 (load unit) SHALL always win contention, the pointer SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-022 Single request: req0 valid, adr=2, data=16'hFFFF -> req0_ready=1 the same cycle; next cycle write_en=1, write_adr=2, write_data=16'hFFFF, grant_id=0.
REQ-023 Contention with round-robin enabled, after reset: both valid for 4 cycles -> grants 0,1,0,1 and conflict_cnt=4.
REQ-024 Same address: req0 adr=1 data=16'hAAAA and req1 adr=1 data=16'h5555 simultaneously -> two writes to adr 1 on consecutive cycles; the second carries the loser's data.
REQ-025 Reset mid-operation: reset asserted in the cycle after a transfer -> write_en=0 on that edge; all outputs zero; no write for the requests present in the reset cycle.
REQ-026 Saturation: both valid for 300 cycles -> conflict_cnt reaches 255 and stays at 255.
REQ-027 Macro undefined: both valid for 3 cycles -> grant_id=1 on all three writes, and req0_ready stays 0.
